accumulate_unit: RTL and testbench
==================================

# accumulate_unit

Sequential operand/accumulator stage directly upstream of the 16-bit carry-select adder. It holds the accumulator register A and operand register B and drives both onto the adder inputs. It registers the adder's sum and carry back into A on each Run press, so a single adder forms a running accumulator for switch-and-button board operation. It provides one add per button press, regardless of how long Run is held.

## Interface
Parameters:
- WIDTH, 16, datapath width; must match the adder width.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  level, debounced button; starts one accumulate.
- LoadB  input  1  level; captures SW into B.
- ClearA  input  1  level; zeroes A, C and V.
- Sub  input  1  selects subtract mode (ACCUM_SUB_EN builds only).
- SW  input  WIDTH  operand from switches.
- S  input  WIDTH  sum from the adder (combinational from A_out/B_out/Cin).
- Cout  input  1  carry out from the adder.
- A_out  output  WIDTH  accumulator register; feeds adder A and the display.
- B_out  output  WIDTH  operand presented to adder B.
- Cin  output  1  carry-in to the adder.
- C  output  1  registered carry of the last accumulate.
- V  output  1  registered signed overflow of the last accumulate.
- Busy  output  1  high while not in IDLE.

## Operation
- Reset values: A=0, B=0, C=0, V=0, state=IDLE, Busy=0. Reset overrides every other input, in any state.
- FSM states:
  - IDLE:
    - ClearA=1 zeroes A, C and V. Run is ignored that cycle.
    - Otherwise, Run=1 moves the state to ADD.
    - LoadB=1 loads B<=SW, also in the same cycle as Run; the add then uses the new B.
  - ADD (exactly one cycle): A<=S, C<=Cout, V<=overflow. Go to HOLD.
  - HOLD: stay while Run=1. When Run=0, go to IDLE.
- LoadB and ClearA are ignored outside IDLE.
- Datapath without subtract: B_out=B, Cin=0.
- Overflow: V = (A_out[WIDTH-1]==B_out[WIDTH-1]) && (S[WIDTH-1]!=A_out[WIDTH-1]), evaluated in the ADD cycle.
- All arithmetic is modulo 2^WIDTH. Wrap-around is normal operation and is flagged only by C and V.
- A_out, B_out and Cin are stable throughout ADD. The adder path is purely combinational and must settle within one Clk period.

## Timing
- Run rises and is sampled in IDLE at edge t → state ADD during cycle t..t+1.
- A, C and V take the new values at edge t+1, so they are visible one cycle after ADD is entered: 2-edge latency from Run.
- Busy rises at edge t. It falls at the first edge where HOLD samples Run=0.
- A Run pulse one cycle wide still performs exactly one add: ADD, then HOLD, which exits immediately.
- Run held N cycles produces exactly one add.
- Run must drop for at least one edge in HOLD before the next add can start.
- LoadB→B latency: 1 edge. ClearA→A=0: 1 edge.
- Reset asserted during ADD: A keeps its reset value 0. The ADD result is discarded and the state goes to IDLE.

## Configuration
- ACCUM_SUB_EN defined:
  - Sub is latched into a mode register when the FSM enters ADD from IDLE.
  - With mode=1: B_out=~B, Cin=1, so A<=A-B. C=1 means no borrow. V uses the same formula, applied to the inverted B_out.
  - With mode=0: identical to the plain add.
- ACCUM_SUB_EN undefined: Sub is unused, B_out=B, Cin=0, and no mode register is built.

## Test plan
- Reset, then LoadB with SW=0x0005, then a Run pulse → A_out=0x0005, C=0, V=0. Busy is high for 2 cycles.
- With A=0x0005, hold Run for 10 cycles → exactly one add, A_out=0x000A. No second add until Run drops and rises again.
- With A=0xFFFF and B=0x0001, Run → A_out=0x0000, C=1, V=0. With A=0x7FFF and B=0x0001 → A_out=0x8000, C=0, V=1.
- Assert ClearA and Run in the same IDLE cycle with A=0x1234 → A_out=0x0000, state stays IDLE. Assert LoadB (SW=0x0003) and Run together from A=0 → A_out=0x0003.
- Assert Reset during the ADD cycle with A=0x00FF, B=0x0001 → A_out=0x0000, C=0, Busy=0 on the next cycle.
- ACCUM_SUB_EN build, A=0x0003, B=0x0005, Sub=1, Run → A_out=0xFFFE, C=0 (borrow), V=0.

Source files
------------

// File: rtl/accumulate_unit.sv
// rtl/accumulate_unit.sv - operand/accumulator stage feeding an external carry-select adder
//
// Purpose: holds accumulator A and operand B, presents them to an external
// combinational adder, and captures the adder result back into A exactly
// once per Run press (Run held for any length still gives one add).
//
// Optional feature macro: ACCUM_SUB_EN (adds the subtract mode selected by Sub).
//
// Ports:
//   Clk     in   clock, rising edge
//   Reset   in   synchronous active-high reset
//   Run     in   debounced button, starts one accumulate
//   LoadB   in   capture SW into B (IDLE only)
//   ClearA  in   zero A, C and V (IDLE only, blocks Run that cycle)
//   Sub     in   subtract select (used only with ACCUM_SUB_EN)
//   SW      in   WIDTH-bit switch operand
//   S       in   WIDTH-bit sum from the adder
//   Cout    in   carry out from the adder
//   A_out   out  accumulator register
//   B_out   out  operand to adder B (inverted in subtract mode)
//   Cin     out  carry-in to adder
//   C       out  registered carry of last accumulate
//   V       out  registered signed overflow of last accumulate
//   Busy    out  high whenever the FSM is not in IDLE

module accumulate_unit #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             LoadB,
    input  logic             ClearA,
    input  logic             Sub,
    input  logic [WIDTH-1:0] SW,
    input  logic [WIDTH-1:0] S,
    input  logic             Cout,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             Cin,
    output logic             C,
    output logic             V,
    output logic             Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic             r_v;
    logic             w_start;
    logic             w_overflow;

    // ClearA wins over Run in IDLE so a clear never races an add.
    assign w_start = (r_state == ST_IDLE) && Run && !ClearA;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_ADD;
            ST_ADD:  w_next_state = ST_HOLD;
            ST_HOLD: if (!Run) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef ACCUM_SUB_EN
    logic r_sub;

    // Mode is frozen on entry to ADD so B_out/Cin cannot move mid-add.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sub <= 1'b0;
        end else if (w_start) begin
            r_sub <= Sub;
        end
    end

    assign B_out = r_sub ? ~r_b : r_b;
    assign Cin   = r_sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = Sub;
    assign B_out        = r_b;
    assign Cin          = 1'b0;
`endif

    // Signed overflow: operands agree in sign but the sum does not.
    assign w_overflow = (r_a[WIDTH-1] == B_out[WIDTH-1]) && (S[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (LoadB) begin
                    r_b <= SW;
                end
                if (ClearA) begin
                    r_a <= '0;
                    r_c <= 1'b0;
                    r_v <= 1'b0;
                end
            end
            if (r_state == ST_ADD) begin
                r_a <= S;
                r_c <= Cout;
                r_v <= w_overflow;
            end
        end
    end

    assign A_out = r_a;
    assign C     = r_c;
    assign V     = r_v;
    assign Busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_accumulate_unit.sv
// tb/tb_accumulate_unit.sv - directed self-checking bench for accumulate_unit

module tb_accumulate_unit;

    localparam int WIDTH = 16;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Run;
    logic             LoadB;
    logic             ClearA;
    logic             Sub;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;
    logic             Cin;
    logic             C;
    logic             V;
    logic             Busy;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    // Behavioural stand-in for the external adder.
    assign {Cout, S} = {1'b0, A_out} + {1'b0, B_out} + {{WIDTH{1'b0}}, Cin};

    accumulate_unit #(.WIDTH(WIDTH)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Run    (Run),
        .LoadB  (LoadB),
        .ClearA (ClearA),
        .Sub    (Sub),
        .SW     (SW),
        .S      (S),
        .Cout   (Cout),
        .A_out  (A_out),
        .B_out  (B_out),
        .Cin    (Cin),
        .C      (C),
        .V      (V),
        .Busy   (Busy)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_b(input logic [WIDTH-1:0] val);
        LoadB = 1'b1;
        SW    = val;
        step();
        LoadB = 1'b0;
    endtask

    task automatic clear_a();
        ClearA = 1'b1;
        step();
        ClearA = 1'b0;
    endtask

    // One-cycle Run pulse, then wait through ADD and HOLD back to IDLE.
    task automatic pulse_add();
        Run = 1'b1;
        step();
        Run = 1'b0;
        step();
        step();
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; LoadB = 1'b0; ClearA = 1'b0; Sub = 1'b0; SW = '0;
        step();
        step();
        chk("rst_a",    A_out, 16'h0000);
        chk("rst_b",    B_out, 16'h0000);
        chk("rst_c",    {15'b0, C}, 16'h0);
        chk("rst_v",    {15'b0, V}, 16'h0);
        chk("rst_busy", {15'b0, Busy}, 16'h0);
        Reset = 1'b0;

        // LoadB 5 then single Run pulse
        load_b(16'h0005);
        chk("loadb_b",   B_out, 16'h0005);
        chk("loadb_cin", {15'b0, Cin}, 16'h0);
        Run = 1'b1;
        step();
        Run = 1'b0;
        chk("add_busy1", {15'b0, Busy}, 16'h1);
        chk("add_a_pre", A_out, 16'h0000);
        step();
        chk("add_a",     A_out, 16'h0005);
        chk("add_c",     {15'b0, C}, 16'h0);
        chk("add_v",     {15'b0, V}, 16'h0);
        chk("add_busy2", {15'b0, Busy}, 16'h1);
        step();
        chk("add_busy3", {15'b0, Busy}, 16'h0);

        // Run held 10 cycles: exactly one add
        Run = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("hold_a",    A_out, 16'h000A);
        chk("hold_busy", {15'b0, Busy}, 16'h1);
        Run = 1'b0;
        step();
        chk("hold_exit_busy", {15'b0, Busy}, 16'h0);
        chk("hold_exit_a",    A_out, 16'h000A);

        // 0xFFFF + 1 -> carry, no overflow
        clear_a();
        load_b(16'hFFFF);
        pulse_add();
        chk("ffff_a", A_out, 16'hFFFF);
        load_b(16'h0001);
        pulse_add();
        chk("wrap_a", A_out, 16'h0000);
        chk("wrap_c", {15'b0, C}, 16'h1);
        chk("wrap_v", {15'b0, V}, 16'h0);

        // 0x7FFF + 1 -> signed overflow
        clear_a();
        chk("clr_c", {15'b0, C}, 16'h0);
        load_b(16'h7FFF);
        pulse_add();
        load_b(16'h0001);
        pulse_add();
        chk("ovf_a", A_out, 16'h8000);
        chk("ovf_c", {15'b0, C}, 16'h0);
        chk("ovf_v", {15'b0, V}, 16'h1);

        // ClearA and Run together: clear wins, no add
        clear_a();
        load_b(16'h1234);
        pulse_add();
        chk("pre_clr_a", A_out, 16'h1234);
        ClearA = 1'b1;
        Run    = 1'b1;
        step();
        ClearA = 1'b0;
        Run    = 1'b0;
        chk("clrrun_a",    A_out, 16'h0000);
        chk("clrrun_busy", {15'b0, Busy}, 16'h0);
        step();
        chk("clrrun_a2",    A_out, 16'h0000);
        chk("clrrun_busy2", {15'b0, Busy}, 16'h0);

        // LoadB and Run together: add uses new B
        LoadB = 1'b1;
        SW    = 16'h0003;
        Run   = 1'b1;
        step();
        LoadB = 1'b0;
        Run   = 1'b0;
        chk("ldrun_busy", {15'b0, Busy}, 16'h1);
        step();
        step();
        chk("ldrun_a", A_out, 16'h0003);

        // Reset during ADD discards the result
        clear_a();
        load_b(16'h00FF);
        pulse_add();
        load_b(16'h0001);
        Run = 1'b1;
        step();
        chk("rstadd_in_add", {15'b0, Busy}, 16'h1);
        Reset = 1'b1;
        Run   = 1'b0;
        step();
        Reset = 1'b0;
        chk("rstadd_a",    A_out, 16'h0000);
        chk("rstadd_c",    {15'b0, C}, 16'h0);
        chk("rstadd_busy", {15'b0, Busy}, 16'h0);
        chk("rstadd_b",    B_out, 16'h0000);

`ifdef ACCUM_SUB_EN
        // 3 - 5 -> 0xFFFE, borrow
        load_b(16'h0003);
        pulse_add();
        load_b(16'h0005);
        Sub = 1'b1;
        Run = 1'b1;
        step();
        Sub = 1'b0;
        Run = 1'b0;
        chk("sub_bout", B_out, 16'hFFFA);
        chk("sub_cin",  {15'b0, Cin}, 16'h1);
        step();
        step();
        chk("sub_a", A_out, 16'hFFFE);
        chk("sub_c", {15'b0, C}, 16'h0);
        chk("sub_v", {15'b0, V}, 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
